// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device clocks,
// ACK check and timeout. Drives the shared lines through open-drain enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       tx_active,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d, ack_q, ack_d, tmo_q, tmo_d;
    logic          c_s1_q, c_s2_q, c_prev_q, d_s1_q, d_s2_q;
    logic          fe;

    assign fe = c_prev_q & ~c_s2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        c_oe_d    = c_oe_q;
        d_oe_d    = d_oe_q;
        done_d    = 1'b0;
        ack_d     = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shreg_d  = tx_data;
                    parity_d = ~^tx_data;
                    cnt_d    = '0;
                    c_oe_d   = 1'b1;
                    d_oe_d   = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Data goes low one cycle before the clock is released.
                if (cnt_q == INH_LAST) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == INH_DATA) d_oe_d = 1'b1;
                end
            end
            REQ: begin
                c_oe_d    = 1'b0;
                d_oe_d    = 1'b1;
                bit_idx_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (fe) begin
                    if (bit_idx_q < 4'd11) bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q < 4'd8) begin
                        d_oe_d = ~shreg_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        d_oe_d = ~parity_q;
                    end else if (bit_idx_q == 4'd9) begin
                        d_oe_d = 1'b0;
                    end else if (bit_idx_q == 4'd10) begin
                        if (!d_s2_q) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (c_s2_q && d_s2_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout overrides whatever the states above decided, including fe 11.
        if (state_q == REQ || state_q == SHIFT || state_q == WAIT_IDLE) begin
            if (cnt_q == TMO_LAST) begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                ack_d   = 1'b0;
                done_d  = 1'b0;
                tmo_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            tmo_q     <= 1'b0;
            c_s1_q    <= 1'b1;
            c_s2_q    <= 1'b1;
            c_prev_q  <= 1'b1;
            d_s1_q    <= 1'b1;
            d_s2_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            tmo_q     <= tmo_d;
            c_s1_q    <= ps2c_in;
            c_s2_q    <= c_s1_q;
            c_prev_q  <= c_s2_q;
            d_s1_q    <= ps2d_in;
            d_s2_q    <= d_s1_q;
        end
    end

    assign ps2c_oe     = c_oe_q;
    assign ps2d_oe     = d_oe_q;
    assign busy        = busy_q;
    assign tx_active   = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a small open-drain PS/2 device model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, busy, tx_active, done, ack_err, timeout_err;

    int errors = 0;
    int checks = 0;
    int n_done = 0, n_ack = 0, n_tmo = 0;

    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_data & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .busy(busy), .tx_active(tx_active), .done(done), .ack_err(ack_err),
        .timeout_err(timeout_err)
    );

    always @(negedge clk) begin
        if (done) n_done++;
        if (ack_err) n_ack++;
        if (timeout_err) n_tmo++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("tx_active_rise", tx_active, 1);
    endtask

    // Returns at the first negedge with the clock released (REQ cycle).
    task automatic inhibit_phase();
        int cnt = 0;
        int d_at = 0;
        while (ps2c_oe && cnt < 5000) begin
            cnt++;
            if (ps2d_oe && d_at == 0) d_at = cnt;
            @(negedge clk);
        end
        chk("inhibit_len", cnt, 20);
        chk("data_low_at", d_at, 20);
        chk("start_bit", ps2d_in, 0);
    endtask

    task automatic dev_frame(input logic ack_val, input int poke_at, input int abort_at,
                             output logic [9:0] bits);
        bits = '0;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (k == poke_at && i == 0) begin
                    tx_data  = 8'h00;
                    tx_start = 1'b1;
                end
                @(negedge clk);
                if (k == poke_at && i == 0) tx_start = 1'b0;
                if (k == abort_at && i == 6) begin
                    reset = 1'b0;
                    @(negedge clk);
                    chk("abort_c_oe", ps2c_oe, 0);
                    chk("abort_d_oe", ps2d_oe, 0);
                    chk("abort_busy", busy, 0);
                    reset    = 1'b1;
                    dev_clk  = 1'b1;
                    dev_data = 1'b1;
                    repeat (5) @(negedge clk);
                    return;
                end
            end
            bits[k-1] = ps2d_in;
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_data = ack_val;
        @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall", busy, 0);
        chk("c_oe_idle", ps2c_oe, 0);
        chk("d_oe_idle", ps2d_oe, 0);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, a0, t0, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_c_oe", ps2c_oe, 0);
        chk("rst_d_oe", ps2d_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_pulses", {done, ack_err, timeout_err}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xED, parity 1, stop 1
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hED);
        inhibit_phase();
        dev_frame(1'b0, 0, 0, bits);
        chk("ed_bits", bits, 10'h3ED);
        wait_not_busy();
        chk("ed_done", n_done - d0, 1);
        chk("ed_noerr", (n_ack - a0) + (n_tmo - t0), 0);

        // 2: 0xF4, parity 0
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hF4);
        inhibit_phase();
        dev_frame(1'b0, 0, 0, bits);
        chk("f4_bits", bits, 10'h2F4);
        wait_not_busy();
        chk("f4_done", n_done - d0, 1);
        chk("f4_noerr", (n_ack - a0) + (n_tmo - t0), 0);

        // 3: device leaves data high at ACK
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hF4);
        inhibit_phase();
        dev_frame(1'b1, 0, 0, bits);
        wait_not_busy();
        chk("nack_ack_err", n_ack - a0, 1);
        chk("nack_no_done", n_done - d0, 0);
        chk("nack_no_tmo", n_tmo - t0, 0);

        // 4: device silent, timeout 2000 clks after REQ entry
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hFF);
        inhibit_phase();
        n = 0;
        while (!timeout_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", n, 2000);
        chk("tmo_c_oe", ps2c_oe, 0);
        chk("tmo_d_oe", ps2d_oe, 0);
        chk("tmo_busy", busy, 0);
        @(negedge clk);
        chk("tmo_once", n_tmo - t0, 1);
        chk("tmo_no_other", (n_done - d0) + (n_ack - a0), 0);

        // 5: restart request mid-frame is ignored
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hED);
        inhibit_phase();
        dev_frame(1'b0, 4, 0, bits);
        chk("poke_bits", bits, 10'h3ED);
        wait_not_busy();
        chk("poke_done", n_done - d0, 1);
        repeat (30) @(negedge clk);
        chk("poke_no_restart", busy, 0);

        // 6: reset after fe 5, then a clean 0xFF send
        d0 = n_done; a0 = n_ack; t0 = n_tmo;
        start_tx(8'hED);
        inhibit_phase();
        dev_frame(1'b0, 0, 5, bits);
        chk("abort_no_pulse", (n_done - d0) + (n_ack - a0) + (n_tmo - t0), 0);
        d0 = n_done;
        start_tx(8'hFF);
        inhibit_phase();
        dev_frame(1'b0, 0, 0, bits);
        chk("ff_bits", bits, 10'h3FF);
        wait_not_busy();
        chk("ff_done", n_done - d0, 1);
        chk("ff_tx_active", tx_active, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter that sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset. It is the outbound counterpart of the keyboard scan-code receiver and shares the same ps2c/ps2d lines through open-drain pull-downs. It runs the full request-to-send sequence, shifts out data, parity and stop bits on device-generated clocks, and checks the device acknowledge. It asserts tx_active so the receiver ignores the line while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds ps2c low before the request (100 us at 50 MHz); minimum 2
TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK sample (15 ms at 50 MHz)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset
tx_data  in  8  command byte; sampled only when a start is accepted
tx_start  in  1  one-cycle start request
ps2c_in  in  1  raw PS/2 clock line (asynchronous)
ps2d_in  in  1  raw PS/2 data line (asynchronous)
ps2c_oe  out  1  1 = pull ps2c low, 0 = release
ps2d_oe  out  1  1 = pull ps2d low, 0 = release
busy  out  1  high from start acceptance until the cycle before returning to IDLE
tx_active  out  1  same as busy; used to gate the receiver
done  out  1  one-cycle pulse: frame sent and ACK seen low
ack_err  out  1  one-cycle pulse: ACK sampled high
timeout_err  out  1  one-cycle pulse: TIMEOUT_CYCLES expired

Behaviour:
- Synchronisation: ps2c_in and ps2d_in each pass through a 2-FF synchroniser. A falling-edge event (fe) is high for one clk when the previous synchronised clock is 1 and the current one is 0.
- Reset (reset==0 at a posedge): state=IDLE, ps2c_oe=0, ps2d_oe=0, busy=0, tx_active=0, done=0, ack_err=0, timeout_err=0, all counters 0. Reset in mid-frame releases both lines on that same edge.
- Start acceptance: in IDLE with tx_start=1, latch tx_data into shreg, latch parity = ~^tx_data (odd parity), then go to INHIBIT. tx_start is ignored in any other state; there is no queuing.
- INHIBIT: ps2c_oe=1, ps2d_oe=0, count INHIBIT_CYCLES clks. On the final count set ps2d_oe=1 (start bit 0) and go to REQ.
- REQ: ps2c_oe=0, ps2d_oe=1. Clear bit_idx, clear the timeout counter, go to SHIFT.
- SHIFT: advance only on fe.
  - fe 1..8: ps2d_oe = ~shreg[bit_idx], data sent LSB first.
  - fe 9: ps2d_oe = ~parity.
  - fe 10: ps2d_oe = 0 (stop bit, line released).
  - fe 11: sample synchronised ps2d. If 0, go to WAIT_IDLE. If 1, pulse ack_err and go to IDLE.
  - bit_idx is 4 bits, range 0..11, and never wraps.
- WAIT_IDLE: wait until both synchronised lines read 1 in the same cycle, then pulse done and go to IDLE. This state is also covered by the timeout.
- Timeout: the counter runs in REQ, SHIFT and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1, release both lines, pulse timeout_err and go to IDLE. If fe 11 arrives on the same cycle as the timeout, the timeout wins.
- Pulse exclusivity: exactly one of done, ack_err or timeout_err pulses per accepted start. busy falls on the same edge as that pulse.
- busy/tx_active: 1 in INHIBIT, REQ, SHIFT and WAIT_IDLE; 0 in IDLE.
- Latency: busy rises 1 clk after tx_start. ps2c_oe is high for exactly INHIBIT_CYCLES clks. ps2d_oe rises on the last inhibit cycle.
- Output timing: ps2c_oe and ps2d_oe are registered outputs with no combinational path from any input.

Test Plan:
1. Normal send, INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, BFM device clocks at 40-clk period, tx_data=0xED. Required: ps2c_oe high for 20 clks; bits sampled on device rising edges read 0,1,0,1,1,0,1,1,1 (start, LSB-first data, parity=1) then stop=1; BFM ACK low; done pulses once; busy=0 afterwards.
2. tx_data=0xF4. Required: data bits 0,0,1,0,1,1,1,1; parity=0; done pulses.
3. BFM leaves data high at the ACK slot. Required: ack_err pulses once, done never pulses, both oe=0, state returns to IDLE.
4. BFM never generates clocks. Required: timeout_err pulses 2000 clks after REQ entry, both oe=0, busy=0.
5. tx_start pulsed again mid-frame with tx_data=0x00. Required: it is ignored and the frame in flight (0xED) completes unchanged.
6. reset=0 asserted after fe 5. Required: ps2c_oe=0, ps2d_oe=0, busy=0 on the next posedge; a new 0xFF send after reset completes with parity=1 and done.
